// File: rtl/fpu_issue_pkg.sv
// Shared types for the FPU issue controller: op encoding and FSM states.
package fpu_issue_pkg;

  typedef enum logic [1:0] {
    FPU_ADD = 2'b00,
    FPU_SUB = 2'b01,
    FPU_MUL = 2'b10,
    FPU_DIV = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_WAIT  = 2'b10,
    S_WB    = 2'b11
  } fpu_state_e;

  localparam logic [1:0] FPU_OP_DIV = 2'b11;

endpackage

// File: rtl/fpu_wb_arbiter.sv
// Regfile write-port mux: ALU always wins; a displaced FPU result parks in a
// one-entry hold register and drains on the first ALU-free cycle.
module fpu_wb_arbiter #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_wr_en,
  input  logic [RADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0]  alu_wr_data,
  input  logic               fpu_wr,
  input  logic               fpu_cap,
  input  logic [2:0]         fpu_dst,
  input  logic [DATA_W-1:0]  fpu_result,
  output logic               rf_wr_en,
  output logic [RADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]  rf_wr_data
);

  logic              hold_vld;
  logic [DATA_W-1:0] hold_data;
  logic [RADDR_W-1:0] fpu_addr;

  assign fpu_addr = {{(RADDR_W-3){1'b0}}, fpu_dst};

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (fpu_cap) begin
      hold_vld  <= 1'b1;
      hold_data <= fpu_result;
    end else if (hold_vld && !alu_wr_en) begin
      hold_vld  <= 1'b0;
    end
  end

  // FPU-sourced writes are suppressed under reset so an abandoned op never lands.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    if (alu_wr_en) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = alu_wr_addr;
      rf_wr_data = alu_wr_data;
    end else if (!reset && fpu_wr) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = fpu_addr;
      rf_wr_data = fpu_result;
    end else if (!reset && hold_vld) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = fpu_addr;
      rf_wr_data = hold_data;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue/sequencing FSM with hazard stall and timeout.
// FPU_ISSUE_STICKY_FLAGS_EN adds flags_clr / sticky_flags accumulation.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int RADDR_W     = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [1:0]         issue_op,
  input  logic [2:0]         issue_dst,
  input  logic [RADDR_W-1:0] dec_rd_addr0,
  input  logic [RADDR_W-1:0] dec_rd_addr1,
  output logic               fpu_start,
  output logic [1:0]         fpu_op,
  input  logic               fpu_busy,
  input  logic               fpu_valid,
  input  logic [DATA_W-1:0]  fpu_result,
  input  logic [2:0]         fpu_flags,
  input  logic               alu_wr_en,
  input  logic [RADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0]  alu_wr_data,
  output logic               rf_wr_en,
  output logic [RADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]  rf_wr_data,
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
  input  logic               flags_clr,
  output logic [2:0]         sticky_flags,
`endif
  output logic               stall,
  output logic               fpu_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  fpu_state_e       state, state_nxt;
  fpu_op_e          op_q;
  logic [2:0]       dst_q;
  logic             pending;
  logic [CNT_W-1:0] cnt;
  logic             fpu_wr, fpu_cap;
  logic [RADDR_W-1:0] dst_ext;

  assign dst_ext = {{(RADDR_W-3){1'b0}}, dst_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= FPU_ADD;
      dst_q   <= '0;
      pending <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_START) begin
        op_q    <= fpu_op_e'(issue_op);
        dst_q   <= issue_dst;
        pending <= 1'b1;
      end else if (state != S_IDLE && state_nxt == S_IDLE) begin
        pending <= 1'b0;
      end
      if (state == S_START)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    fpu_start = 1'b0;
    fpu_error = 1'b0;
    fpu_wr    = 1'b0;
    fpu_cap   = 1'b0;
    case (state)
      S_IDLE:  if (issue_valid && !fpu_busy) state_nxt = S_START;
      S_START: begin
        fpu_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (fpu_valid) begin
          if (alu_wr_en) begin
            fpu_cap   = 1'b1;
            state_nxt = S_WB;
          end else begin
            fpu_wr    = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (cnt == TO_LAST) begin
          fpu_error = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WB:    if (!alu_wr_en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A blocked issue in IDLE (fpu_busy) also holds the front end.
  assign stall = (issue_valid && (state != S_IDLE || fpu_busy))
               | (pending && (dec_rd_addr0 == dst_ext || dec_rd_addr1 == dst_ext))
               | (state == S_START) | (state == S_WB);

  assign fpu_op = (state == S_START || state == S_WAIT) ? op_q : 2'b00;

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset)                         sticky_flags <= '0;
    else if (state == S_WAIT && fpu_valid) sticky_flags <= (flags_clr ? 3'b000 : sticky_flags) | fpu_flags;
    else if (flags_clr)                sticky_flags <= '0;
  end
`else
  logic unused_flags;
  assign unused_flags = ^fpu_flags;
`endif

  fpu_wb_arbiter #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_wb (
    .clk        (clk),
    .reset      (reset),
    .alu_wr_en  (alu_wr_en),
    .alu_wr_addr(alu_wr_addr),
    .alu_wr_data(alu_wr_data),
    .fpu_wr     (fpu_wr),
    .fpu_cap    (fpu_cap),
    .fpu_dst    (dst_q),
    .fpu_result (fpu_result),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data)
  );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed-vector bench for fpu_issue_ctrl; sticky-flag checks compile in
// when FPU_ISSUE_STICKY_FLAGS_EN is defined.
module tb_fpu_issue_ctrl;
  import fpu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [1:0]  issue_op;
  logic [2:0]  issue_dst;
  logic [3:0]  dec_rd_addr0, dec_rd_addr1;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic        fpu_busy, fpu_valid;
  logic [15:0] fpu_result;
  logic [2:0]  fpu_flags;
  logic        alu_wr_en;
  logic [3:0]  alu_wr_addr;
  logic [15:0] alu_wr_data;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic        stall, fpu_error;
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
  logic        flags_clr;
  logic [2:0]  sticky_flags;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_dst(issue_dst),
    .dec_rd_addr0(dec_rd_addr0), .dec_rd_addr1(dec_rd_addr1),
    .fpu_start(fpu_start), .fpu_op(fpu_op),
    .fpu_busy(fpu_busy), .fpu_valid(fpu_valid), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .alu_wr_en(alu_wr_en), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    .flags_clr(flags_clr), .sticky_flags(sticky_flags),
`endif
    .stall(stall), .fpu_error(fpu_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    issue_valid = 0; issue_op = 0; issue_dst = 0;
    dec_rd_addr0 = 4'hF; dec_rd_addr1 = 4'hF;
    fpu_busy = 0; fpu_valid = 0; fpu_result = 0; fpu_flags = 0;
    alu_wr_en = 0; alu_wr_addr = 0; alu_wr_data = 0;
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    flags_clr = 0;
`endif
  endtask

  // Drive the accept cycle N, return #1 into cycle N+1 with issue dropped.
  task automatic do_issue(input logic [1:0] op, input logic [2:0] dst);
    tick();
    issue_valid = 1; issue_op = op; issue_dst = dst;
    tick();
    issue_valid = 0;
  endtask

  initial begin
    bit ok;
    idle_in();
    reset = 1;
    tick(); tick();
    chk("rst_start", fpu_start, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rfwe",  rf_wr_en, 0);
    chk("rst_err",   fpu_error, 0);
    chk("rst_op",    fpu_op, 0);
    chk("rst_state", dut.state, S_IDLE);
    reset = 0;

    // ADD dst=3, result on N+4
    tick();
    issue_valid = 1; issue_op = 2'b00; issue_dst = 3; #1;
    chk("add_N_stall", stall, 0);
    chk("add_N_start", fpu_start, 0);
    tick(); issue_valid = 0; #1;
    chk("add_N1_start", fpu_start, 1);
    chk("add_N1_stall", stall, 1);
    tick(); #1;
    chk("add_N2_start", fpu_start, 0);
    chk("add_N2_stall", stall, 0);
    tick(); #1;
    chk("add_N3_stall", stall, 0);
    tick(); fpu_valid = 1; fpu_result = 16'h3C00; #1;
    chk("add_N4_we",   rf_wr_en, 1);
    chk("add_N4_addr", rf_wr_addr, 3);
    chk("add_N4_data", rf_wr_data, 16'h3C00);
    chk("add_N4_stall", stall, 0);
    tick(); fpu_valid = 0; #1;
    chk("add_N5_we", rf_wr_en, 0);
    chk("add_N5_state", dut.state, S_IDLE);

    // fpu_valid while IDLE is ignored
    fpu_valid = 1; fpu_result = 16'h1234; #1;
    chk("stray_valid_we", rf_wr_en, 0);
    fpu_valid = 0;

    // issue while fpu_busy: held off, stalled
    tick(); issue_valid = 1; issue_op = 2'b10; fpu_busy = 1; #1;
    chk("busy_stall", stall, 1);
    tick(); #1;
    chk("busy_state", dut.state, S_IDLE);
    chk("busy_start", fpu_start, 0);
    issue_valid = 0; fpu_busy = 0;

    // DIV dst=5, decode reads r5 -> stall until result
    do_issue(FPU_OP_DIV, 5);
    dec_rd_addr0 = 5; #1;
    chk("div_start", fpu_start, 1);
    chk("div_op_start", fpu_op, 3);
    chk("div_stall_start", stall, 1);
    ok = 1;
    for (int i = 0; i < 16; i++) begin
      tick(); #1;
      if (stall !== 1'b1 || fpu_op !== 2'b11) ok = 0;
    end
    chk("div_stall_wait", ok, 1);
    tick(); fpu_valid = 1; fpu_result = 16'h4000; #1;
    chk("div_we",    rf_wr_en, 1);
    chk("div_addr",  rf_wr_addr, 5);
    chk("div_stall_wr", stall, 1);
    tick(); fpu_valid = 0; #1;
    chk("div_stall_after", stall, 0);
    dec_rd_addr0 = 4'hF;

    // Collision: SUB dst=2 vs ALU r4, then ALU r6 during WB, then drain
    do_issue(2'b01, 2);
    tick(); dec_rd_addr1 = 2; #1;
    chk("col_haz1_stall", stall, 1);
    tick(); fpu_valid = 1; fpu_result = 16'h4200;
    alu_wr_en = 1; alu_wr_addr = 4; alu_wr_data = 16'h0007; #1;
    chk("col_addr", rf_wr_addr, 4);
    chk("col_data", rf_wr_data, 16'h0007);
    tick(); fpu_valid = 0; alu_wr_addr = 6; alu_wr_data = 16'h0009; #1;
    chk("col_wb_alu_addr", rf_wr_addr, 6);
    chk("col_wb_stall", stall, 1);
    tick(); alu_wr_en = 0; #1;
    chk("col_drain_we",   rf_wr_en, 1);
    chk("col_drain_addr", rf_wr_addr, 2);
    chk("col_drain_data", rf_wr_data, 16'h4200);
    chk("col_drain_stall", stall, 1);
    tick(); #1;
    chk("col_after_we", rf_wr_en, 0);
    chk("col_after_stall", stall, 0);
    dec_rd_addr1 = 4'hF;

    // Timeout: MUL with no fpu_valid
    do_issue(2'b10, 1);
    ok = 1;
    for (int i = 0; i < 31; i++) begin
      tick(); #1;
      if (fpu_error !== 1'b0 || rf_wr_en !== 1'b0) ok = 0;
    end
    chk("to_early", ok, 1);
    tick(); #1;
    chk("to_err",  fpu_error, 1);
    chk("to_we",   rf_wr_en, 0);
    chk("to_op",   fpu_op, 2);
    tick(); #1;
    chk("to_err_clr", fpu_error, 0);
    chk("to_state",   dut.state, S_IDLE);
    chk("to_stall",   stall, 0);

    // Reset while in WB: held result discarded
    do_issue(2'b00, 6);
    tick(); fpu_valid = 1; fpu_result = 16'hBEEF; alu_wr_en = 1; alu_wr_addr = 1; #1;
    tick(); fpu_valid = 0; alu_wr_en = 0; reset = 1; #1;
    chk("rstwb_we", rf_wr_en, 0);
    tick(); reset = 0; #1;
    chk("rstwb_state", dut.state, S_IDLE);
    chk("rstwb_we2", rf_wr_en, 0);
    chk("rstwb_stall", stall, 0);

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    chk("sticky_rst", sticky_flags, 0);
    do_issue(2'b00, 0);
    tick(); fpu_valid = 1; fpu_flags = 3'b001; #1;
    tick(); fpu_valid = 0; fpu_flags = 0; #1;
    chk("sticky_1", sticky_flags, 3'b001);
    do_issue(2'b10, 1);
    tick(); fpu_valid = 1; fpu_flags = 3'b100; #1;
    tick(); fpu_valid = 0; fpu_flags = 0; #1;
    chk("sticky_2", sticky_flags, 3'b101);
    flags_clr = 1;
    tick(); flags_clr = 0; #1;
    chk("sticky_clr", sticky_flags, 3'b000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
